// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: two-producer burst write arbiter feeding one FIFO write port.
// Define FIFO_WR_ARB_STATS_EN to add saturating beats0/beats1/stalls counters.
module fifo_wr_arbiter #(
  parameter int BURST_MAX = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0,
  input  logic       req1,
  input  logic [7:0] data0,
  input  logic [7:0] data1,
  input  logic       full,
  output logic       gnt0,
  output logic       gnt1,
  output logic       write_enb,
  output logic [7:0] datain
`ifdef FIFO_WR_ARB_STATS_EN
  ,
  output logic [15:0] beats0,
  output logic [15:0] beats1,
  output logic [15:0] stalls
`endif
);
  typedef enum logic [1:0] {IDLE, G0, G1} state_t;
  state_t state, state_nx;
  logic [7:0] cnt, cnt_nx;
  logic last, last_nx;
  logic own_req, oth_req, beat, done;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      last  <= 1'b1;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      last  <= last_nx;
    end
  always_comb begin
    own_req  = state == G1 ? req1 : req0;
    oth_req  = state == G1 ? req0 : req1;
    beat     = state != IDLE && own_req && !full;
    done     = !own_req || (beat && ({1'b0, cnt} + 9'd1 == 9'(BURST_MAX)));
    state_nx = state;
    cnt_nx   = beat ? cnt + 8'd1 : cnt;
    last_nx  = last;
    if (state == IDLE)
      state_nx = req0 && req1 ? (last ? G0 : G1) : req0 ? G0 : req1 ? G1 : IDLE;
    else if (done) begin
      // the other requester always gets the next burst; otherwise re-grant or go idle
      state_nx = oth_req ? (state == G0 ? G1 : G0) : own_req ? state : IDLE;
      cnt_nx   = '0;
      last_nx  = state == G1;
    end
  end
  always_comb begin
    gnt0      = state == G0 && req0 && !full;
    gnt1      = state == G1 && req1 && !full;
    write_enb = gnt0 | gnt1;
    datain    = state == G0 ? data0 : state == G1 ? data1 : 8'h00;
  end
`ifdef FIFO_WR_ARB_STATS_EN
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      beats0 <= '0;
      beats1 <= '0;
      stalls <= '0;
    end else begin
      if (gnt0 && beats0 != 16'hFFFF) beats0 <= beats0 + 16'd1;
      if (gnt1 && beats1 != 16'hFFFF) beats1 <= beats1 + 16'd1;
      if (state != IDLE && own_req && full && stalls != 16'hFFFF) stalls <= stalls + 16'd1;
    end
`endif
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: scoreboard bench with a per-cycle reference model of the arbiter.
module tb_fifo_wr_arbiter;
  localparam int BM = 4;
  logic clk = 1'b0, reset = 1'b1, req0 = 1'b0, req1 = 1'b0, full = 1'b0;
  logic [7:0] data0 = '0, data1 = '0;
  logic gnt0, gnt1, write_enb;
  logic [7:0] datain;
`ifdef FIFO_WR_ARB_STATS_EN
  logic [15:0] beats0, beats1, stalls;
`endif

  fifo_wr_arbiter #(.BURST_MAX(BM)) dut (
    .clk(clk), .reset(reset), .req0(req0), .req1(req1), .data0(data0), .data1(data1),
    .gnt0(gnt0), .gnt1(gnt1), .full(full), .write_enb(write_enb), .datain(datain)
`ifdef FIFO_WR_ARB_STATS_EN
    , .beats0(beats0), .beats1(beats1), .stalls(stalls)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic g0;
    logic g1;
    logic [7:0] d;
    int b0;
    int b1;
    int st;
  } exp_t;

  exp_t q[$];
  logic [7:0] wr_log[$];
  int checks = 0, errors = 0;
  // reference model: owner 0=none, 1=producer0, 2=producer1
  int m_own = 0, m_cnt = 0, m_last = 1, m_b0 = 0, m_b1 = 0, m_stl = 0;
  logic last_we = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_own = 0; m_cnt = 0; m_last = 1; m_b0 = 0; m_b1 = 0; m_stl = 0;
  endtask

  task automatic cycle(input logic r, input logic r0, input logic r1, input logic f,
                       input logic [7:0] d0, input logic [7:0] d1);
    exp_t e;
    int n;
    logic rn, rm, beat;
    @(posedge clk);
    #1;
    reset = r; req0 = r0; req1 = r1; full = f; data0 = d0; data1 = d1;
    if (r) begin
      model_reset();
      e.g0 = 0; e.g1 = 0; e.d = 8'h00; e.b0 = 0; e.b1 = 0; e.st = 0;
    end else begin
      e.b0 = m_b0; e.b1 = m_b1; e.st = m_stl;
      e.g0 = m_own == 1 && r0 && !f;
      e.g1 = m_own == 2 && r1 && !f;
      e.d  = m_own == 1 ? d0 : m_own == 2 ? d1 : 8'h00;
      if (e.g0 && m_b0 < 65535) m_b0++;
      if (e.g1 && m_b1 < 65535) m_b1++;
      if (((m_own == 1 && r0) || (m_own == 2 && r1)) && f && m_stl < 65535) m_stl++;
      if (m_own == 0) begin
        if (r0 && r1) m_own = m_last == 0 ? 2 : 1;
        else if (r0) m_own = 1;
        else if (r1) m_own = 2;
      end else begin
        n = m_own - 1;
        rn = n == 1 ? r1 : r0;
        rm = n == 1 ? r0 : r1;
        beat = e.g0 | e.g1;
        if (beat) m_cnt++;
        if (!rn || (beat && m_cnt == BM)) begin
          m_last = n;
          m_cnt = 0;
          m_own = rm ? 2 - n : (rn ? m_own : 0);
        end
      end
    end
    last_we = e.g0 | e.g1;
    q.push_back(e);
  endtask

  task automatic flush();
    @(negedge clk);
    #1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("gnt0", gnt0, e.g0);
        chk("gnt1", gnt1, e.g1);
        chk("write_enb", write_enb, e.g0 | e.g1);
        chk("datain", datain, e.d);
`ifdef FIFO_WR_ARB_STATS_EN
        chk("beats0", beats0, e.b0);
        chk("beats1", beats1, e.b1);
        chk("stalls", stalls, e.st);
`endif
        if (write_enb) wr_log.push_back(datain);
      end
    end
  end

  initial begin : stim
    logic r0, r1;
    repeat (3) cycle(1, 0, 0, 0, 8'h00, 8'h00);
    // single producer: idle cycle, one 4-beat burst, immediate re-grant
    wr_log.delete();
    repeat (6) cycle(0, 1, 0, 0, 8'h03, 8'h00);
    flush();
    chk("single_beats", wr_log.size(), 5);
    foreach (wr_log[i]) chk("single_data", wr_log[i], 8'h03);
    // both requesting: bursts alternate with no gaps
    cycle(1, 0, 0, 0, 8'h00, 8'h00);
    wr_log.delete();
    repeat (13) cycle(0, 1, 1, 0, 8'hA5, 8'h5A);
    flush();
    chk("alt_beats", wr_log.size(), 12);
    for (int i = 0; i < 12 && i < wr_log.size(); i++)
      chk("alt_data", wr_log[i], (i / 4 == 1) ? 8'h5A : 8'hA5);
    // G1 stalled by full mid-burst, then hands over to G0
    cycle(1, 0, 0, 0, 8'h00, 8'h00);
    cycle(0, 0, 1, 0, 8'h11, 8'h77);
    repeat (2) cycle(0, 0, 1, 0, 8'h11, 8'h77);
    repeat (3) cycle(0, 1, 1, 1, 8'h11, 8'h77);
    repeat (2) cycle(0, 1, 1, 0, 8'h11, 8'h77);
    cycle(0, 1, 0, 0, 8'h11, 8'h77);
    flush();
    chk("stall_handover", datain, 8'h11);
`ifdef FIFO_WR_ARB_STATS_EN
    chk("stalls_total", stalls, 3);
    chk("beats1_total", beats1, 4);
`endif
    // req1 withdrawn after one beat while req0 waits
    cycle(1, 0, 0, 0, 8'h00, 8'h00);
    cycle(0, 0, 1, 0, 8'h22, 8'h33);
    cycle(0, 1, 1, 0, 8'h22, 8'h33);
    cycle(0, 1, 0, 0, 8'h22, 8'h33);
    repeat (3) cycle(0, 1, 1, 0, 8'h22, 8'h33);
    // async reset mid-burst, then tie goes to producer 0
    cycle(1, 0, 0, 0, 8'h00, 8'h00);
    repeat (3) cycle(0, 1, 1, 0, 8'h44, 8'h55);
    flush();
    chk("we_pre_reset", write_enb, last_we);
    reset = 1'b1;
    model_reset();
    #1;
    chk("we_async_reset", write_enb, 1'b0);
    chk("gnt0_async_reset", gnt0, 1'b0);
    chk("datain_async_reset", datain, 8'h00);
    cycle(1, 1, 1, 0, 8'h44, 8'h55);
    repeat (3) cycle(0, 1, 1, 0, 8'h44, 8'h55);
    // random traffic with sticky requests, random full and rare resets
    r0 = 1'b0;
    r1 = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) r0 = ~r0;
      if ($urandom_range(0, 3) == 0) r1 = ~r1;
      cycle($urandom_range(0, 199) == 0, r0, r1, $urandom_range(0, 3) == 0,
            8'($urandom), 8'($urandom));
    end
    flush();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 The block SHALL have parameter BURST_MAX, default 4, legal range 1..255, giving the maximum beats per grant.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 The block SHALL have ports req0 and req1, input, 1 each, producer write requests held until served.
REQ-005 The block SHALL have ports data0 and data1, input, 8 each, producer write data.
REQ-006 The block SHALL have ports gnt0 and gnt1, output, 1 each, beat accepted from that producer this cycle.
REQ-007 The block SHALL have port full, input, 1, the FIFO full flag.
REQ-008 The block SHALL have port write_enb, output, 1, the FIFO write strobe.
REQ-009 The block SHALL have port datain, output, 8, the FIFO write data.

Function
REQ-010 The block SHALL implement states IDLE, G0 and G1, plus a beat counter (8-bit) and a last-served pointer (1-bit).
REQ-011 IDLE transitions: only req0 -> G0; only req1 -> G1; both -> the requester not equal to last-served; neither -> stay IDLE; no beat is written in IDLE.
REQ-012 In Gn, gntn and write_enb SHALL be 1 in the same cycle iff reqn=1 and full=0 (zero-cycle combinational path from state, reqn, full).
REQ-013 In Gn, datain SHALL equal datan; in IDLE datain SHALL be 8'h00.
REQ-014 gnt0 and gnt1 SHALL never both be 1; write_enb SHALL equal gnt0|gnt1.
REQ-015 Each accepted beat SHALL increment the beat counter; full=1 SHALL hold state and counter unchanged, with no preemption by the other requester.
REQ-016 Gn SHALL be exited at the clock edge after either reqn=0 or the accepted beat that makes beat count equal BURST_MAX.
REQ-017 On exit from Gn, next state SHALL be Gm (other) if reqm=1, else Gn with counter cleared if reqn=1, else IDLE.
REQ-018 On every exit from Gn, last-served SHALL be set to n and the beat counter SHALL be cleared.
REQ-019 reqn dropping while full=1 in Gn SHALL exit per REQ-016/017 with no beat written.

Reset
REQ-020 While reset=1, state SHALL be IDLE, beat counter 0, and last-served 1 (so req0 wins the first tie).
REQ-021 While reset=1, the outputs SHALL be gnt0=0, gnt1=0, write_enb=0 and datain=8'h00, asynchronously, including mid-burst.
REQ-022 After reset deasserts, the first grant state SHALL be entered no earlier than the first rising edge with reset=0.

Configuration
REQ-023 With macro FIFO_WR_ARB_STATS_EN defined, the block SHALL add outputs beats0[15:0], beats1[15:0] and stalls[15:0].
REQ-024 The stats counters SHALL count gnt0 beats, gnt1 beats, and cycles in G0/G1 with reqn=1 and full=1, each saturating at 16'hFFFF.
REQ-025 The stats counters SHALL be cleared by reset.
REQ-026 Without FIFO_WR_ARB_STATS_EN, those ports and counters SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-027 Reset release, req0=1 only, data0=8'h03, full=0 -> IDLE one cycle, then four consecutive write_enb beats of 8'h03 with gnt0=1, then one IDLE-free regrant to G0 (counter cleared).
REQ-028 req0=req1=1 continuously, BURST_MAX=4 -> write pattern 4x data0, 4x data1, 4x data0, with no idle cycles between bursts.
REQ-029 In G1 after 2 beats, full=1 for 3 cycles -> write_enb=0 and gnt1=0 for 3 cycles, then remaining 2 beats of data1, then switch to G0 if req0=1.
REQ-030 reset asserted asynchronously mid-burst in G0 -> write_enb drops before the next clock edge; after release with req0=req1=1, G0 is granted first.
REQ-031 req1 deasserted after 1 beat while req0=1 -> exit at next edge to G0, last-served=1.
REQ-032 With FIFO_WR_ARB_STATS_EN, after REQ-029 stimulus -> stalls=3, beats1=4.
